// File: rtl/bus_host_arbiter_if.sv
// Host-side and device-side signal bundle for bus_host_arbiter.
// slave = arbiter view, master = the requesters/device environment.
interface bus_host_arbiter_if #(
  parameter int NrHosts      = 2,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  logic [NrHosts-1:0]                         host_req_i;
  logic [NrHosts-1:0]                         host_gnt_o;
  logic [NrHosts-1:0][AddressWidth-1:0]       host_addr_i;
  logic [NrHosts-1:0]                         host_we_i;
  logic [NrHosts-1:0][DataWidth/8-1:0]        host_be_i;
  logic [NrHosts-1:0][DataWidth-1:0]          host_wdata_i;
  logic [NrHosts-1:0]                         host_rvalid_o;
  logic [DataWidth-1:0]                       host_rdata_o;
  logic [NrHosts-1:0]                         host_err_o;
  logic                                       dev_req_o;
  logic                                       dev_gnt_i;
  logic [AddressWidth-1:0]                    dev_addr_o;
  logic                                       dev_we_o;
  logic [DataWidth/8-1:0]                     dev_be_o;
  logic [DataWidth-1:0]                       dev_wdata_o;
  logic                                       dev_rvalid_i;
  logic [DataWidth-1:0]                       dev_rdata_i;
  logic                                       dev_err_i;
  logic                                       spurious_rsp_o;

  modport slave (
    input  host_req_i, host_addr_i, host_we_i,
    input  host_be_i, host_wdata_i,
    input  dev_gnt_i, dev_rvalid_i,
    input  dev_rdata_i, dev_err_i,
    output host_gnt_o, host_rvalid_o,
    output host_rdata_o, host_err_o,
    output dev_req_o, dev_addr_o, dev_we_o,
    output dev_be_o, dev_wdata_o,
    output spurious_rsp_o
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i,
    output host_be_i, host_wdata_i,
    output dev_gnt_i, dev_rvalid_i,
    output dev_rdata_i, dev_err_i,
    input  host_gnt_o, host_rvalid_o,
    input  host_rdata_o, host_err_o,
    input  dev_req_o, dev_addr_o, dev_we_o,
    input  dev_be_o, dev_wdata_o,
    input  spurious_rsp_o
  );
endinterface

// File: rtl/bus_host_arbiter.sv
// Round-robin share of one req/gnt/rvalid host port, in-order ID FIFO.
// Define BUS_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module bus_host_arbiter #(
  parameter int NrHosts        = 2,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  bus_host_arbiter_if.slave bus
);
  localparam int PW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int CW = $clog2(MaxOutstanding + 1);
  localparam int FW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [NrHosts-1:0] ONE = NrHosts'(1);

  logic [PW-1:0] w_start;
  logic [PW-1:0] w_sel;
  logic          w_any;
  logic          w_full;
  logic          w_empty;
  logic          w_hs;
  logic          w_pop;
  logic [PW-1:0] w_head;

  logic [PW-1:0] r_fifo [MaxOutstanding];
  logic [FW-1:0] r_wptr;
  logic [FW-1:0] r_rptr;
  logic [CW-1:0] r_count;

`ifdef BUS_ARB_FIXED_PRIO_EN
  assign w_start = '0;
`else
  logic [PW-1:0] r_rr_ptr;

  assign w_start = r_rr_ptr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
    end else if (w_hs) begin
      r_rr_ptr <= (w_sel == PW'(NrHosts - 1)) ? '0 : w_sel + 1'b1;
    end
  end
`endif

  always_comb begin
    logic [PW-1:0] idx;
    idx   = '0;
    w_any = 1'b0;
    w_sel = '0;
    for (int i = 0; i < NrHosts; i++) begin
      idx = PW'((int'(w_start) + i) % NrHosts);
      if (!w_any && bus.host_req_i[idx]) begin
        w_any = 1'b1;
        w_sel = idx;
      end
    end
  end

  assign w_full  = (r_count == CW'(MaxOutstanding));
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rptr];
  // Full blocks requests even when a pop lands in the same cycle.
  assign w_hs    = bus.dev_req_o & bus.dev_gnt_i;
  assign w_pop   = bus.dev_rvalid_i & ~w_empty;

  assign bus.dev_req_o   = w_any & ~w_full;
  assign bus.dev_addr_o  = w_any ? bus.host_addr_i[w_sel]  : '0;
  assign bus.dev_we_o    = w_any ? bus.host_we_i[w_sel]    : 1'b0;
  assign bus.dev_be_o    = w_any ? bus.host_be_i[w_sel]    : '0;
  assign bus.dev_wdata_o = w_any ? bus.host_wdata_i[w_sel] : '0;

  assign bus.host_gnt_o     = w_hs ? (ONE << w_sel) : '0;
  assign bus.host_rvalid_o  = w_pop ? (ONE << w_head) : '0;
  assign bus.host_err_o     = (w_pop & bus.dev_err_i) ? (ONE << w_head) : '0;
  assign bus.host_rdata_o   = bus.dev_rdata_i;
  assign bus.spurious_rsp_o = bus.dev_rvalid_i & w_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < MaxOutstanding; i++) r_fifo[i] <= '0;
    end else begin
      if (w_hs) begin
        r_fifo[r_wptr] <= w_sel;
        r_wptr <= (r_wptr == FW'(MaxOutstanding - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == FW'(MaxOutstanding - 1)) ? '0 : r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else begin
      unique case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
